// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the two-requester UART transmit arbiter.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
package uart_arb_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,  // waiting for a lock with the UART quiet
    ST_SETTLE  = 2'd1,  // baud generator retuning after a speed change
    ST_GRANTED = 2'd2,  // owner may strobe bytes
    ST_DRAIN   = 2'd3   // owner released; waiting for the last byte to leave
  } arb_state_t;

  // Requester identity, used for both the owner and the round-robin pointer.
  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_t;

  // Baud select codes driven onto speed_sel.
  localparam logic SPEED_SLOW = 1'b0;
  localparam logic SPEED_FAST = 1'b1;

  // Default settle time after a baud change (legal range 1..255).
  localparam int SETTLE_CYCLES_DEFAULT = 16;

  // Settle counter width; wide enough for the largest legal settle time.
  localparam int CNT_W = 8;

  // The requester that is not r; used to advance the round-robin pointer.
  function automatic req_t other_req(input req_t r);
    return (r == REQ_A) ? REQ_B : REQ_A;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter.sv
// Arbitrates two byte requesters onto one UART transmitter, retuning baud between owners.
// Latency: accepted send strobe appears on tx_send/tx_data one clock later.
// Backpressure: x_busy high blocks strobes; strobes made while busy are dropped.
//
// Ports:
//   clk, rst                 system clock, asynchronous active-high reset
//   a_/b_lock                requester holds the channel for a whole message while high
//   a_/b_speed               baud the requester needs (SPEED_SLOW / SPEED_FAST)
//   a_/b_data, a_/b_send     byte and one-cycle strobe from each requester
//   a_/b_busy, a_/b_grant    per-requester flow control and ownership
//   tx_data, tx_send         registered byte and strobe to the UART transmitter
//   tx_busy                  UART busy, rises the cycle after tx_send is sampled
//   speed_sel                registered baud select to the UART baud generator
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,

  input  logic       a_lock,
  input  logic       a_speed,
  input  logic [7:0] a_data,
  input  logic       a_send,
  output logic       a_busy,
  output logic       a_grant,

  input  logic       b_lock,
  input  logic       b_speed,
  input  logic [7:0] b_data,
  input  logic       b_send,
  output logic       b_busy,
  output logic       b_grant,

  output logic [7:0] tx_data,
  output logic       tx_send,
  input  logic       tx_busy,
  output logic       speed_sel
);

  // Last count value spent in SETTLE; the counter starts at zero on entry,
  // so SETTLE lasts exactly SETTLE_CYCLES clocks.
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  arb_state_t       state;
  arb_state_t       state_nxt;
  req_t             owner;
  req_t             rr;
  logic [CNT_W-1:0] cnt;

  // Arbitration and owner-side decode.
  logic       arb_go;      // a new owner is chosen this cycle
  req_t       pick;        // candidate owner if arbitration happens
  logic       pick_speed;  // baud the candidate needs
  logic       speed_chg;   // candidate needs a different baud than speed_sel
  logic       own_lock;
  logic       own_send;
  logic [7:0] own_data;
  logic       own_open;    // owner may strobe: granted, UART idle, no strobe in flight
  logic       send_ok;     // owner strobe accepted this cycle

  always_comb begin
    // Contention resolves to the round-robin pointer; otherwise the sole locker.
    if (a_lock && b_lock) begin
      pick = rr;
    end else if (a_lock) begin
      pick = REQ_A;
    end else begin
      pick = REQ_B;
    end

    pick_speed = (pick == REQ_A) ? a_speed : b_speed;
    speed_chg  = (pick_speed != speed_sel);
    arb_go     = (state == ST_IDLE) && (a_lock || b_lock) && !tx_busy;

    own_lock = (owner == REQ_A) ? a_lock : b_lock;
    own_send = (owner == REQ_A) ? a_send : b_send;
    own_data = (owner == REQ_A) ? a_data : b_data;

    // tx_send is included so a second strobe cannot slip in before the
    // UART has had a chance to raise tx_busy for the first one.
    own_open = (state == ST_GRANTED) && !tx_busy && !tx_send;
    send_ok  = own_open && own_send;
  end

  // FSM: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (arb_go) begin
          state_nxt = speed_chg ? ST_SETTLE : ST_GRANTED;
        end
      end
      ST_SETTLE: begin
        // An abandoned lock wins over settle completion.
        if (!own_lock) begin
          state_nxt = ST_IDLE;
        end else if (cnt == SETTLE_LAST) begin
          state_nxt = ST_GRANTED;
        end
      end
      ST_GRANTED: begin
        if (!own_lock) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Wait for both a strobe still in flight and the UART frame itself.
        if (!tx_send && !tx_busy) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs.
  always_comb begin
    a_grant = 1'b0;
    b_grant = 1'b0;
    if ((state == ST_GRANTED) || (state == ST_DRAIN)) begin
      a_grant = (owner == REQ_A);
      b_grant = (owner == REQ_B);
    end
    a_busy = !(own_open && (owner == REQ_A));
    b_busy = !(own_open && (owner == REQ_B));
  end

  // Owner, round-robin pointer, settle counter and baud select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= REQ_A;
      rr        <= REQ_A;
      cnt       <= '0;
      speed_sel <= SPEED_SLOW;
    end else begin
      if (arb_go) begin
        owner <= pick;
        // speed_sel only ever moves on the way into SETTLE; an owner changing
        // its speed input later has no effect until the next arbitration.
        if (speed_chg) begin
          speed_sel <= pick_speed;
          cnt       <= '0;
        end
      end

      if (state == ST_SETTLE) begin
        cnt <= cnt + 1'b1;
      end

      // Only a completed message moves the pointer; an abort in SETTLE leaves it.
      if ((state == ST_DRAIN) && (state_nxt == ST_IDLE)) begin
        rr <= other_req(owner);
      end
    end
  end

  // Transmit register; tx_data holds its value between strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_send <= 1'b0;
      tx_data <= '0;
    end else begin
      tx_send <= send_ok;
      if (send_ok) begin
        tx_data <= own_data;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios then random traffic, against a reference model.
// Latency: model tracks outputs cycle by cycle; a behavioural UART drives tx_busy.
// Backpressure: random strobes deliberately include ones made while busy.
module tb_uart_tx_arbiter;

  localparam int SETTLE = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_lock, a_speed, a_send, a_busy, a_grant;
  logic       b_lock, b_speed, b_send, b_busy, b_grant;
  logic [7:0] a_data, b_data, tx_data;
  logic       tx_send, tx_busy, speed_sel;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst(rst),
    .a_lock(a_lock), .a_speed(a_speed), .a_data(a_data), .a_send(a_send),
    .a_busy(a_busy), .a_grant(a_grant),
    .b_lock(b_lock), .b_speed(b_speed), .b_data(b_data), .b_send(b_send),
    .b_busy(b_busy), .b_grant(b_grant),
    .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy), .speed_sel(speed_sel)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who holds the channel, how much settling remains,
  // whether the holder has let go, who is preferred next, and the UART side.
  int         m_holder;   // -1 none, 0 = A, 1 = B
  int         m_left;     // settle cycles still to wait before the holder is served
  bit         m_rel;      // holder released its lock, last byte still draining
  int         m_pref;     // requester that wins a tie
  bit         m_speed;
  bit         m_send;
  logic [7:0] m_data;

  // Behavioural UART: busy for uart_len cycles after it samples a strobe.
  int uart_left;
  int uart_len;           // 0 = random frame length

  function automatic logic lock_of(input int x);
    return (x == 0) ? a_lock : b_lock;
  endfunction
  function automatic logic speed_of(input int x);
    return (x == 0) ? a_speed : b_speed;
  endfunction
  function automatic logic send_of(input int x);
    return (x == 0) ? a_send : b_send;
  endfunction
  function automatic logic [7:0] data_of(input int x);
    return (x == 0) ? a_data : b_data;
  endfunction
  function automatic bit served(input int x);
    return (m_holder == x) && (m_left == 0) && !m_rel;
  endfunction

  task automatic model_reset();
    m_holder  = -1;
    m_left    = 0;
    m_rel     = 0;
    m_pref    = 0;
    m_speed   = 0;
    m_send    = 0;
    m_data    = 8'h00;
    uart_left = 0;
    tx_busy   = 1'b0;
  endtask

  task automatic check_outputs();
    chk("grant_a", a_grant, 32'((m_holder == 0) && (m_left == 0)));
    chk("grant_b", b_grant, 32'((m_holder == 1) && (m_left == 0)));
    chk("busy_a", a_busy, 32'(!(served(0) && !tx_busy && !m_send)));
    chk("busy_b", b_busy, 32'(!(served(1) && !tx_busy && !m_send)));
    chk("speed_sel", speed_sel, 32'(m_speed));
    chk("tx_send", tx_send, 32'(m_send));
    chk("tx_data", tx_data, 32'(m_data));
  endtask

  // One clock: check outputs, advance the model on current inputs, then
  // return 1 time unit after the rising edge so the caller can drive inputs.
  task automatic step();
    int         p;
    int         n_holder, n_left, n_pref;
    bit         n_rel, n_speed, acc;
    logic [7:0] n_data;
    logic       sent_prev;
    #1;
    check_outputs();

    acc    = (m_holder >= 0) && served(m_holder) && send_of(m_holder) && !tx_busy && !m_send;
    n_data = acc ? data_of(m_holder) : m_data;

    n_holder = m_holder;
    n_left   = m_left;
    n_rel    = m_rel;
    n_pref   = m_pref;
    n_speed  = m_speed;
    if (m_holder < 0) begin
      if (!tx_busy && (a_lock || b_lock)) begin
        if (a_lock && b_lock) p = m_pref;
        else p = a_lock ? 0 : 1;
        n_holder = p;
        if (speed_of(p) != m_speed) begin
          n_speed = speed_of(p);
          n_left  = SETTLE;
        end else begin
          n_left = 0;
        end
      end
    end else if (m_left > 0) begin
      if (!lock_of(m_holder)) begin
        n_holder = -1;
        n_left   = 0;
      end else begin
        n_left = m_left - 1;
      end
    end else if (!m_rel) begin
      if (!lock_of(m_holder)) n_rel = 1;
    end else if (!m_send && !tx_busy) begin
      n_holder = -1;
      n_rel    = 0;
      n_pref   = 1 - m_holder;
    end

    sent_prev = tx_send;
    @(posedge clk);
    #1;
    m_holder = n_holder;
    m_left   = n_left;
    m_rel    = n_rel;
    m_pref   = n_pref;
    m_speed  = n_speed;
    m_send   = acc;
    m_data   = n_data;

    if (sent_prev) uart_left = (uart_len > 0) ? uart_len : int'($urandom_range(2, 6));
    else if (uart_left > 0) uart_left--;
    tx_busy = (uart_left > 0);
  endtask

  task automatic rand_inputs();
    if (a_lock) begin
      if ($urandom_range(0, 11) == 0) a_lock = 1'b0;
    end else if ($urandom_range(0, 5) == 0) a_lock = 1'b1;
    if (b_lock) begin
      if ($urandom_range(0, 11) == 0) b_lock = 1'b0;
    end else if ($urandom_range(0, 5) == 0) b_lock = 1'b1;
    if ($urandom_range(0, 7) == 0) a_speed = ~a_speed;
    if ($urandom_range(0, 7) == 0) b_speed = ~b_speed;
    a_send = ($urandom_range(0, 2) == 0);
    b_send = ($urandom_range(0, 2) == 0);
    a_data = 8'($urandom);
    b_data = 8'($urandom);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_grant_a"}, a_grant, 0);
    chk({tag, "_grant_b"}, b_grant, 0);
    chk({tag, "_busy_a"}, a_busy, 1);
    chk({tag, "_busy_b"}, b_busy, 1);
    chk({tag, "_tx_send"}, tx_send, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_speed"}, speed_sel, 0);
  endtask

  initial begin
    bit got;
    a_lock = 0; a_speed = 0; a_send = 0; a_data = 8'h00;
    b_lock = 0; b_speed = 0; b_send = 0; b_data = 8'h00;
    uart_len = 6;
    rst = 1'b1;
    model_reset();
    #2;
    check_reset_values("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Same speed: no settle, granted on the next edge.
    a_lock = 1; a_speed = 0;
    step(); #1;
    chk("same_speed_grant", a_grant, 1);
    chk("same_speed_sel", speed_sel, 0);
    a_lock = 0;
    repeat (3) step();

    // Speed change: speed_sel moves at once, grant after SETTLE cycles.
    a_lock = 1; a_speed = 1;
    step(); #1;
    chk("settle_speed_sel", speed_sel, 1);
    chk("settle_no_grant", a_grant, 0);
    for (int i = 0; i < SETTLE - 1; i++) begin
      step(); #1;
      chk("settle_wait_grant", a_grant, 0);
      chk("settle_no_send", tx_send, 0);
    end
    step(); #1;
    chk("settle_grant", a_grant, 1);

    // Byte forwarding; B strobes ignored; strobe while busy dropped.
    a_data = 8'h24; a_send = 1; b_data = 8'h99; b_send = 1;
    step();
    a_send = 0; #1;
    chk("send_strobe", tx_send, 1);
    chk("send_data", tx_data, 8'h24);
    chk("send_busy_a", a_busy, 1);
    step(); #1;
    chk("send_once", tx_send, 0);
    chk("send_busy_uart", a_busy, 1);
    a_send = 1; a_data = 8'h55;
    step();
    a_send = 0; b_send = 0; #1;
    chk("busy_drop_send", tx_send, 0);
    chk("busy_drop_data", tx_data, 8'h24);

    // Release while the UART is busy: drain holds the grant.
    a_lock = 0;
    step(); #1;
    chk("drain_grant", a_grant, 1);
    for (int i = 0; i < 20; i++) begin
      if (!tx_busy) break;
      step(); #1;
      chk("drain_hold", a_grant, 1);
    end
    chk("drain_uart_timeout", tx_busy, 0);
    step(); #1;
    chk("drain_exit", a_grant, 0);

    // Pointer now favours B.
    a_lock = 1; b_lock = 1; a_speed = 1; b_speed = 1;
    step(); #1;
    chk("rr_b_grant", b_grant, 1);
    chk("rr_b_not_a", a_grant, 0);

    // Reset while B is granted with a byte in flight.
    b_send = 1; b_data = 8'hA5;
    step();
    b_send = 0; #1;
    chk("pre_rst_send", tx_send, 1);
    rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    model_reset();
    a_lock = 0; b_lock = 0; a_speed = 0; b_speed = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) step();
    #1;
    chk("no_replay", tx_send, 0);

    // Simultaneous contention alternates A, B, A.
    a_lock = 1; b_lock = 1;
    step(); #1;
    chk("contend_first_a", a_grant, 1);
    chk("contend_first_not_b", b_grant, 0);
    a_lock = 0;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      step(); #1;
      if (b_grant) begin
        got = 1;
        break;
      end
    end
    chk("contend_then_b", 32'(got), 1);
    b_lock = 0;
    repeat (3) step();
    a_lock = 1; b_lock = 1;
    step(); #1;
    chk("contend_alt_a", a_grant, 1);
    a_lock = 0; b_lock = 0;
    repeat (3) step();

    // Random traffic with random UART frame lengths.
    uart_len = 0;
    repeat (3000) begin
      rand_inputs();
      step();
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
